// File: rtl/lutram_fifo_pkg.sv
// Shared sizes and RAM32M16 port packing for the 32x14 LUTRAM FIFO controller.
package lutram_fifo_pkg;

  localparam int DEPTH   = 32;
  localparam int PTR_W   = 5;
  localparam int CNT_W   = 6;
  localparam int DATA_W  = 14;
  localparam int LVL_MAX = 33;

  // Seven 2-bit RAM32M16 data ports, index 0 = port A .. index 6 = port G
  typedef logic [6:0][1:0] ram_bus_t;

  // 14-bit word -> {DIG,..,DIA}; DIA carries bits [1:0]
  function automatic ram_bus_t pack_ram_di(input logic [DATA_W-1:0] w);
    ram_bus_t b;
    for (int p = 0; p < 7; p++) b[p] = w[2*p +: 2];
    return b;
  endfunction

  // {DOG,..,DOA} -> 14-bit word, same packing as the write side
  function automatic logic [DATA_W-1:0] unpack_ram_do(input ram_bus_t b);
    logic [DATA_W-1:0] w;
    for (int p = 0; p < 7; p++) w[2*p +: 2] = b[p];
    return w;
  endfunction

endpackage

// File: rtl/lutram_fifo_out_reg.sv
// Registered head-of-FIFO stage: captures the RAM read word on load,
// drops valid when the consumer takes it and nothing new is loaded.
module lutram_fifo_out_reg
  import lutram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  // Load has priority over drop; flush only invalidates, data is left as-is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= din;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lutram_fifo32_ctrl.sv
// Pointer/count controller for a 32-deep x 14-bit FIFO on an external RAM32M16.
// Port H is the write port, ports A..G read the word at rd_ptr (async read).
module lutram_fifo32_ctrl
  import lutram_fifo_pkg::*;
#(
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 2
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  LEVEL,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic              RAM_WE,
  output logic [PTR_W-1:0]  RAM_WADDR,
  output logic [PTR_W-1:0]  RAM_RADDR,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO
);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
    $error("lutram_fifo32_ctrl: AF_LEVEL must be in 1..32");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > LVL_MAX) begin : g_ae_chk
    $error("lutram_fifo32_ctrl: AE_LEVEL must be in 0..33");
  end

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] ram_cnt;
  logic             push, load;
  logic             out_valid;

  // Ready comes only from the count register, never from OUT_READY, so a
  // full RAM frees its slot one cycle after the load that drains it
  assign IN_READY = (ram_cnt != FULL_CNT) & RESETN;
  assign push     = IN_VALID & IN_READY & ~FLUSH;
  // Empty RAM never loads, so a location is never read in its write cycle
  assign load     = (ram_cnt != '0) & (~out_valid | OUT_READY) & ~FLUSH;

  assign RAM_WE    = push;
  assign RAM_WADDR = wr_ptr;
  assign RAM_RADDR = rd_ptr;
  assign RAM_DI    = pack_ram_di(IN_DATA);

  assign OUT_VALID    = out_valid;
  assign LEVEL        = ram_cnt + CNT_W'(out_valid);
  assign ALMOST_FULL  = ram_cnt >= AF_CNT;
  assign ALMOST_EMPTY = LEVEL <= AE_CNT;

  // Pointers wrap 31->0 by width; count tracks RAM occupancy only
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else if (FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  lutram_fifo_out_reg u_out_reg (
    .clk       (CLK),
    .rst_n     (RESETN),
    .flush     (FLUSH),
    .load      (load),
    .out_ready (OUT_READY),
    .din       (unpack_ram_do(RAM_DO)),
    .out_valid (out_valid),
    .out_data  (OUT_DATA)
  );

endmodule

// File: tb/tb_lutram_fifo32_ctrl.sv
// Bench for lutram_fifo32_ctrl with a behavioural 32x14 async-read RAM beside it.
module tb_lutram_fifo32_ctrl;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        FLUSH = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [13:0] IN_DATA = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [13:0] OUT_DATA;
  logic [5:0]  LEVEL;
  logic        ALMOST_FULL, ALMOST_EMPTY;
  logic        RAM_WE;
  logic [4:0]  RAM_WADDR, RAM_RADDR;
  logic [13:0] RAM_DI, RAM_DO;

  logic [13:0] mem [32];

  always #5 CLK = ~CLK;

  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(posedge CLK) if (RAM_WE) mem[RAM_WADDR] <= RAM_DI;
  assign RAM_DO = mem[RAM_RADDR];

  lutram_fifo32_ctrl #(.AF_LEVEL(28), .AE_LEVEL(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR), .RAM_RADDR(RAM_RADDR),
    .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          m_ram = 0;
  bit          m_ov = 1'b0;
  logic [13:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    fork
      // Monitor/scoreboard: sample mid-cycle, compare, then advance the model
      forever begin
        @(negedge CLK or negedge RESETN);
        if (!RESETN) begin
          m_ram = 0;
          m_ov  = 1'b0;
          q.delete();
        end else begin
          bit exp_rdy, m_push, m_load;
          exp_rdy = (m_ram != 32);
          chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
          chk("out_valid", 32'(OUT_VALID), 32'(m_ov));
          chk("level", 32'(LEVEL), 32'(m_ram + int'(m_ov)));
          chk("almost_full", 32'(ALMOST_FULL), 32'(m_ram >= 28));
          chk("almost_empty", 32'(ALMOST_EMPTY), 32'((m_ram + int'(m_ov)) <= 2));
          m_push = IN_VALID && exp_rdy && !FLUSH;
          m_load = (m_ram != 0) && (!m_ov || OUT_READY) && !FLUSH;
          chk("ram_we", 32'(RAM_WE), 32'(m_push));
          if (FLUSH) begin
            m_ram = 0;
            m_ov  = 1'b0;
            q.delete();
          end else begin
            if (m_ov && OUT_READY) begin
              if (q.size() == 0) chk("underflow", 32'(OUT_DATA), 32'hFFFF_FFFF);
              else chk("out_data", 32'(OUT_DATA), 32'(q.pop_front()));
            end
            if (m_push) begin
              q.push_back(IN_DATA);
              n_acc++;
            end
            m_ram = m_ram + int'(m_push) - int'(m_load);
            if (m_load) m_ov = 1'b1;
            else if (OUT_READY) m_ov = 1'b0;
          end
        end
      end

      // Directed stimulus
      begin
        int base, cyc;
        // 1: reset values
        #2;
        chk("rst_in_ready", 32'(IN_READY), 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        step(); step();
        RESETN = 1'b1;
        step();
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_ready", 32'(IN_READY), 32'd1);
        chk("rst_ae", 32'(ALMOST_EMPTY), 32'd1);
        chk("rst_af", 32'(ALMOST_FULL), 32'd0);

        // 2: latency
        IN_VALID = 1'b1; IN_DATA = 14'h2A5C; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0;
        chk("lat_level_e0", 32'(LEVEL), 32'd1);
        chk("lat_valid_e0", 32'(OUT_VALID), 32'd0);
        step();
        chk("lat_valid_e1", 32'(OUT_VALID), 32'd1);
        chk("lat_data_e1", 32'(OUT_DATA), 32'h2A5C);
        chk("lat_level_e1", 32'(LEVEL), 32'd1);
        step();
        chk("lat_level_e2", 32'(LEVEL), 32'd0);
        OUT_READY = 1'b0;

        // 3: fill with 40 offered words, no consumer
        base = n_acc;
        for (int i = 0; i < 40; i++) begin
          IN_VALID = 1'b1; IN_DATA = 14'(i);
          step();
        end
        IN_VALID = 1'b0;
        step();
        chk("fill_accepted", 32'(n_acc - base), 32'd33);
        chk("fill_level", 32'(LEVEL), 32'd33);
        chk("fill_data", 32'(OUT_DATA), 32'd0);
        chk("fill_ready", 32'(IN_READY), 32'd0);
        chk("fill_af", 32'(ALMOST_FULL), 32'd1);

        // 5: take one word while full, then a push+load cycle
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        chk("sim_level", 32'(LEVEL), 32'd32);
        chk("sim_ready", 32'(IN_READY), 32'd1);
        chk("sim_data", 32'(OUT_DATA), 32'd1);
        IN_VALID = 1'b1; IN_DATA = 14'h1111; OUT_READY = 1'b1;
        step();
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        chk("pl_level", 32'(LEVEL), 32'd32);
        chk("pl_data", 32'(OUT_DATA), 32'd2);

        // 6: drain to 10 held, then flush with IN_VALID high
        OUT_READY = 1'b1;
        repeat (22) step();
        OUT_READY = 1'b0;
        chk("pre_flush_level", 32'(LEVEL), 32'd10);
        FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 14'h3FFF;
        #1;
        chk("flush_we", 32'(RAM_WE), 32'd0);
        step();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        chk("flush_level", 32'(LEVEL), 32'd0);
        chk("flush_valid", 32'(OUT_VALID), 32'd0);
        IN_VALID = 1'b1; IN_DATA = 14'h0BEE;
        step();
        IN_VALID = 1'b0;
        step();
        chk("post_flush_valid", 32'(OUT_VALID), 32'd1);
        chk("post_flush_data", 32'(OUT_DATA), 32'h0BEE);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;

        // 4: 100 words, random handshakes; scoreboard checks order
        base = n_acc;
        cyc = 0;
        while ((n_acc - base) < 100 && cyc < 3000) begin
          IN_VALID  = 1'($urandom_range(0, 1));
          IN_DATA   = 14'(16'h0100 + 16'(n_acc - base) * 16'd37);
          OUT_READY = 1'($urandom_range(0, 1));
          step();
          cyc++;
        end
        chk("rand_accepted", 32'(n_acc - base), 32'd100);
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        cyc = 0;
        while ((m_ram + int'(m_ov)) != 0 && cyc < 100) begin
          step();
          cyc++;
        end
        chk("rand_drained", 32'(LEVEL), 32'd0);
        chk("rand_queue_empty", 32'(q.size()), 32'd0);
        OUT_READY = 1'b0;

        // Reset mid-stream: output must go invalid without a clock edge
        IN_VALID = 1'b1; IN_DATA = 14'h0555;
        repeat (3) step();
        IN_VALID = 1'b0;
        #2;
        RESETN = 1'b0;
        #1;
        chk("async_valid", 32'(OUT_VALID), 32'd0);
        chk("async_level", 32'(LEVEL), 32'd0);
        chk("async_ready", 32'(IN_READY), 32'd0);
        step(); step();
        RESETN = 1'b1;
        step();
        chk("post_rst_level", 32'(LEVEL), 32'd0);
        chk("post_rst_ready", 32'(IN_READY), 32'd1);
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
